// File: rtl/aq_fadd_maxmin_ex3_pack_pkg.sv
// -----------------------------------------------------------------------------
// aq_fadd_maxmin_ex3_pack_pkg
// Shared vfalu definitions for the max/min/compare result packing path:
//   - result width
//   - one-hot positions of the format select {double, single, half, bhalf}
//   - NaN-box constants for results narrower than 64 bits
//   - one-hot legality helper
// -----------------------------------------------------------------------------
package aq_fadd_maxmin_ex3_pack_pkg;

   localparam int RST_W = 64;
   localparam int FMT_W = 4;

   // Bit positions inside ex2_fmt
   localparam int FMT_DOUBLE_BIT = 3;
   localparam int FMT_SINGLE_BIT = 2;
   localparam int FMT_HALF_BIT   = 1;
   localparam int FMT_BHALF_BIT  = 0;

   localparam logic [FMT_W-1:0] FMT_DOUBLE = 4'b1000;
   localparam logic [FMT_W-1:0] FMT_SINGLE = 4'b0100;
   localparam logic [FMT_W-1:0] FMT_HALF   = 4'b0010;
   localparam logic [FMT_W-1:0] FMT_BHALF  = 4'b0001;

   // Upper-bit fill for narrow results
   localparam logic [31:0] NANBOX_SINGLE = 32'hFFFF_FFFF;
   localparam logic [47:0] NANBOX_HALF   = 48'hFFFF_FFFF_FFFF;

   function automatic logic fmt_is_onehot(input logic [FMT_W-1:0] fmt);
      return (fmt != '0) && ((fmt & (fmt - 4'd1)) == '0);
   endfunction

endpackage

// File: rtl/aq_fadd_maxmin_pack.sv
// -----------------------------------------------------------------------------
// aq_fadd_maxmin_pack
// Combinational EX2 result packer for max/min/compare ops.
// Ports:
//   op_cmp            : op is a compare (result is the 1-bit compare outcome)
//   fmt               : one-hot {double, single, half, bhalf}
//   sel_sign/sel_e    : selected sign / exponent (already in target bias)
//   double_f..bhalf_f : selected fraction per format
//   cmp_r             : compare outcome
//   special_vld       : special-case result applies
//   special_rst       : pre-packed special result
//   pack_rst          : final 64-bit result
//   pack_legal        : 0 when a max/min op carries a non-one-hot format
// -----------------------------------------------------------------------------
module aq_fadd_maxmin_pack
   import aq_fadd_maxmin_ex3_pack_pkg::*;
(
   input  logic             op_cmp,
   input  logic [FMT_W-1:0] fmt,
   input  logic             sel_sign,
   input  logic [10:0]      sel_e,
   input  logic [51:0]      double_f,
   input  logic [22:0]      single_f,
   input  logic [9:0]       half_f,
   input  logic [6:0]       bhalf_f,
   input  logic             cmp_r,
   input  logic             special_vld,
   input  logic [RST_W-1:0] special_rst,
   output logic [RST_W-1:0] pack_rst,
   output logic             pack_legal
);

   always_comb begin
      pack_rst   = '0;
      pack_legal = 1'b1;
      if (op_cmp) begin
         pack_rst = {{(RST_W-1){1'b0}}, cmp_r};
      end else if (special_vld) begin
         pack_rst = special_rst;
      end else begin
         // Narrow formats only use the low exponent bits.
         case (fmt)
            FMT_DOUBLE: pack_rst = {sel_sign, sel_e, double_f};
            FMT_SINGLE: pack_rst = {NANBOX_SINGLE, sel_sign, sel_e[7:0], single_f};
            FMT_HALF:   pack_rst = {NANBOX_HALF, sel_sign, sel_e[4:0], half_f};
            FMT_BHALF:  pack_rst = {NANBOX_HALF, sel_sign, sel_e[7:0], bhalf_f};
            default: begin
               pack_rst   = '0;
               pack_legal = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/aq_fadd_maxmin_ex3_pack.sv
// -----------------------------------------------------------------------------
// aq_fadd_maxmin_ex3_pack
// EX2->EX3 pipeline register for max/min/compare results. Packing happens in
// EX2 so EX3 only stores the final 64-bit value and its NV flag.
// Ports:
//   forever_cpuclk, cpurst      : clock, async active-high reset
//   ex2_*                       : EX2 op, selected fields, special/cmp info
//   ex3_flush, ex3_stall        : kill EX3 / downstream not ready
//   ex3_rst_vld, ex3_rst        : EX3 valid and packed result
//   ex3_fflags_nv               : NV flag accompanying ex3_rst
//   ex2_stall                   : EX2 must hold (EX3 full and stalled)
// -----------------------------------------------------------------------------
module aq_fadd_maxmin_ex3_pack
   import aq_fadd_maxmin_ex3_pack_pkg::*;
(
   input  logic             forever_cpuclk,
   input  logic             cpurst,
   input  logic             ex2_pipe_vld,
   input  logic             ex2_op_cmp,
   input  logic [FMT_W-1:0] ex2_fmt,
   input  logic             ex2_sel_final_sign,
   input  logic [10:0]      ex2_sel_final_e,
   input  logic [51:0]      ex2_double_sel_final_f,
   input  logic [22:0]      ex2_single0_sel_final_f,
   input  logic [9:0]       ex2_half0_sel_final_f,
   input  logic [6:0]       ex2_bhalf0_sel_final_f,
   input  logic             double_pipe_ex2_cmp_r,
   input  logic             ex2_special_value_vld,
   input  logic [RST_W-1:0] ex2_special_rst,
   input  logic             ex2_nv,
   input  logic             ex3_flush,
   input  logic             ex3_stall,
   output logic             ex3_rst_vld,
   output logic [RST_W-1:0] ex3_rst,
   output logic             ex3_fflags_nv,
   output logic             ex2_stall
);

   logic [RST_W-1:0] pack_rst_p0;
   logic             pack_legal_p0;
   logic             capture_p0;

   logic             vld_p1;
   logic [RST_W-1:0] rst_p1;
   logic             nv_p1;

   // ---- EX2: pack and decide capture ----
   aq_fadd_maxmin_pack u_pack (
      .op_cmp      (ex2_op_cmp),
      .fmt         (ex2_fmt),
      .sel_sign    (ex2_sel_final_sign),
      .sel_e       (ex2_sel_final_e),
      .double_f    (ex2_double_sel_final_f),
      .single_f    (ex2_single0_sel_final_f),
      .half_f      (ex2_half0_sel_final_f),
      .bhalf_f     (ex2_bhalf0_sel_final_f),
      .cmp_r       (double_pipe_ex2_cmp_r),
      .special_vld (ex2_special_value_vld),
      .special_rst (ex2_special_rst),
      .pack_rst    (pack_rst_p0),
      .pack_legal  (pack_legal_p0)
   );

   assign ex2_stall  = vld_p1 & ex3_stall;
   assign capture_p0 = ex2_pipe_vld & ~ex2_stall & ~ex3_flush;

   // ---- EX3: registered result ----
   // Flush wins over capture; a stalled valid op holds; otherwise drain.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         vld_p1 <= 1'b0;
      end else if (ex3_flush) begin
         vld_p1 <= 1'b0;
      end else if (capture_p0) begin
         vld_p1 <= 1'b1;
      end else if (!ex3_stall) begin
         vld_p1 <= 1'b0;
      end
   end

   // Payload enable is exactly the capture condition; not cleared on drain/flush.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         rst_p1 <= '0;
         nv_p1  <= 1'b0;
      end else if (capture_p0) begin
         rst_p1 <= pack_rst_p0;
         nv_p1  <= ex2_nv & pack_legal_p0;
      end
   end

   assign ex3_rst_vld   = vld_p1;
   assign ex3_rst       = rst_p1;
   assign ex3_fflags_nv = nv_p1;

endmodule

// File: tb/tb_aq_fadd_maxmin_ex3_pack.sv
module tb_aq_fadd_maxmin_ex3_pack;

   logic        forever_cpuclk;
   logic        cpurst;
   logic        ex2_pipe_vld;
   logic        ex2_op_cmp;
   logic [3:0]  ex2_fmt;
   logic        ex2_sel_final_sign;
   logic [10:0] ex2_sel_final_e;
   logic [51:0] ex2_double_sel_final_f;
   logic [22:0] ex2_single0_sel_final_f;
   logic [9:0]  ex2_half0_sel_final_f;
   logic [6:0]  ex2_bhalf0_sel_final_f;
   logic        double_pipe_ex2_cmp_r;
   logic        ex2_special_value_vld;
   logic [63:0] ex2_special_rst;
   logic        ex2_nv;
   logic        ex3_flush;
   logic        ex3_stall;
   logic        ex3_rst_vld;
   logic [63:0] ex3_rst;
   logic        ex3_fflags_nv;
   logic        ex2_stall;

   int tests_run;
   int tests_failed;

   aq_fadd_maxmin_ex3_pack dut (
      .forever_cpuclk          (forever_cpuclk),
      .cpurst                  (cpurst),
      .ex2_pipe_vld            (ex2_pipe_vld),
      .ex2_op_cmp              (ex2_op_cmp),
      .ex2_fmt                 (ex2_fmt),
      .ex2_sel_final_sign      (ex2_sel_final_sign),
      .ex2_sel_final_e         (ex2_sel_final_e),
      .ex2_double_sel_final_f  (ex2_double_sel_final_f),
      .ex2_single0_sel_final_f (ex2_single0_sel_final_f),
      .ex2_half0_sel_final_f   (ex2_half0_sel_final_f),
      .ex2_bhalf0_sel_final_f  (ex2_bhalf0_sel_final_f),
      .double_pipe_ex2_cmp_r   (double_pipe_ex2_cmp_r),
      .ex2_special_value_vld   (ex2_special_value_vld),
      .ex2_special_rst         (ex2_special_rst),
      .ex2_nv                  (ex2_nv),
      .ex3_flush               (ex3_flush),
      .ex3_stall               (ex3_stall),
      .ex3_rst_vld             (ex3_rst_vld),
      .ex3_rst                 (ex3_rst),
      .ex3_fflags_nv           (ex3_fflags_nv),
      .ex2_stall               (ex2_stall)
   );

   initial forever_cpuclk = 1'b0;
   always #5 forever_cpuclk = ~forever_cpuclk;

   // Reference packing written straight from the format rules.
   function automatic logic [63:0] ref_pack(
      input logic        cmp, input logic [3:0] fmt, input logic s,
      input logic [10:0] e, input logic [51:0] fd, input logic [22:0] fs,
      input logic [9:0]  fh, input logic [6:0] fb, input logic cr,
      input logic        spv, input logic [63:0] sp);
      logic [63:0] r;
      if (cmp) r = 64'(cr);
      else if (spv) r = sp;
      else if (fmt == 4'b1000) r = {s, e, fd};
      else if (fmt == 4'b0100) r = (64'hFFFF_FFFF << 32) | (64'(s) << 31) | (64'(e[7:0]) << 23) | 64'(fs);
      else if (fmt == 4'b0010) r = (64'hFFFF_FFFF_FFFF << 16) | (64'(s) << 15) | (64'(e[4:0]) << 10) | 64'(fh);
      else if (fmt == 4'b0001) r = (64'hFFFF_FFFF_FFFF << 16) | (64'(s) << 15) | (64'(e[7:0]) << 7) | 64'(fb);
      else r = 64'h0;
      return r;
   endfunction

   task automatic step();
      @(posedge forever_cpuclk);
      #1;
   endtask

   task automatic set_idle();
      ex2_pipe_vld = 0; ex2_op_cmp = 0; ex2_fmt = 4'b1000; ex2_sel_final_sign = 0;
      ex2_sel_final_e = 0; ex2_double_sel_final_f = 0; ex2_single0_sel_final_f = 0;
      ex2_half0_sel_final_f = 0; ex2_bhalf0_sel_final_f = 0; double_pipe_ex2_cmp_r = 0;
      ex2_special_value_vld = 0; ex2_special_rst = 0; ex2_nv = 0;
      ex3_flush = 0; ex3_stall = 0;
   endtask

   task automatic set_op(input logic cmp, input logic [3:0] fmt, input logic s,
                         input logic [10:0] e, input logic [51:0] fd, input logic [22:0] fs,
                         input logic [9:0] fh, input logic [6:0] fb, input logic cr,
                         input logic spv, input logic [63:0] sp, input logic nv);
      ex2_pipe_vld = 1; ex2_op_cmp = cmp; ex2_fmt = fmt; ex2_sel_final_sign = s;
      ex2_sel_final_e = e; ex2_double_sel_final_f = fd; ex2_single0_sel_final_f = fs;
      ex2_half0_sel_final_f = fh; ex2_bhalf0_sel_final_f = fb; double_pipe_ex2_cmp_r = cr;
      ex2_special_value_vld = spv; ex2_special_rst = sp; ex2_nv = nv;
   endtask

   task automatic do_reset();
      set_idle();
      cpurst = 1;
      step();
      step();
      cpurst = 0;
      #1;
   endtask

   task automatic test_reset();
      set_idle();
      cpurst = 1;
      #2;
      tests_run++;
      if (ex3_rst_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_vld got=%b exp=0", ex3_rst_vld); end
      tests_run++;
      if (ex3_rst !== 64'h0) begin tests_failed++; $display("FAIL reset_rst got=%h exp=0", ex3_rst); end
      tests_run++;
      if (ex3_fflags_nv !== 1'b0) begin tests_failed++; $display("FAIL reset_nv got=%b exp=0", ex3_fflags_nv); end
      tests_run++;
      if (ex2_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_ex2_stall got=%b exp=0", ex2_stall); end
      step();
      cpurst = 0;
      #1;
   endtask

   task automatic test_formats();
      // double max
      set_op(0, 4'b1000, 0, 11'h400, 52'h0, 0, 0, 0, 0, 0, 0, 0);
      step();
      tests_run++;
      if (ex3_rst_vld !== 1'b1 || ex3_rst !== 64'h4000_0000_0000_0000)
         begin tests_failed++; $display("FAIL double_max got=%b/%h exp=1/4000000000000000", ex3_rst_vld, ex3_rst); end
      // single min, NaN-boxed
      set_op(0, 4'b0100, 1, 11'h07F, 0, 23'h0, 0, 0, 0, 0, 0, 0);
      step();
      tests_run++;
      if (ex3_rst_vld !== 1'b1 || ex3_rst !== 64'hFFFF_FFFF_BF80_0000)
         begin tests_failed++; $display("FAIL single_min got=%b/%h exp=1/ffffffffbf800000", ex3_rst_vld, ex3_rst); end
      // compare with NV
      set_op(1, 4'b1000, 1, 11'h7FF, 52'hF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0, 0, 1);
      step();
      tests_run++;
      if (ex3_rst !== 64'h1 || ex3_fflags_nv !== 1'b1)
         begin tests_failed++; $display("FAIL cmp_nv got=%h/%b exp=1/1", ex3_rst, ex3_fflags_nv); end
      // half: upper exponent bits ignored
      set_op(0, 4'b0010, 0, 11'h7EF, 0, 0, 10'h200, 0, 0, 0, 0, 0);
      step();
      tests_run++;
      if (ex3_rst !== 64'hFFFF_FFFF_FFFF_3E00 || ex3_fflags_nv !== 1'b0)
         begin tests_failed++; $display("FAIL half got=%h/%b exp=ffffffffffff3e00/0", ex3_rst, ex3_fflags_nv); end
      // bhalf
      set_op(0, 4'b0001, 1, 11'h780, 0, 0, 0, 7'h40, 0, 0, 0, 0);
      step();
      tests_run++;
      if (ex3_rst !== 64'hFFFF_FFFF_FFFF_C040)
         begin tests_failed++; $display("FAIL bhalf got=%h exp=ffffffffffffc040", ex3_rst); end
      // special passthrough with NV
      set_op(0, 4'b0100, 1, 11'h123, 0, 23'h1, 0, 0, 0, 1, 64'h7FF8_0000_0000_0000, 1);
      step();
      tests_run++;
      if (ex3_rst !== 64'h7FF8_0000_0000_0000 || ex3_fflags_nv !== 1'b1)
         begin tests_failed++; $display("FAIL special got=%h/%b exp=7ff8000000000000/1", ex3_rst, ex3_fflags_nv); end
      // drain: valid drops, payload kept
      set_idle();
      step();
      tests_run++;
      if (ex3_rst_vld !== 1'b0 || ex3_rst !== 64'h7FF8_0000_0000_0000)
         begin tests_failed++; $display("FAIL drain got=%b/%h exp=0/7ff8000000000000", ex3_rst_vld, ex3_rst); end
   endtask

   task automatic test_stall();
      set_op(0, 4'b1000, 0, 11'h3FF, 52'h1, 0, 0, 0, 0, 0, 0, 0);   // A
      step();
      set_op(0, 4'b1000, 1, 11'h401, 52'h2, 0, 0, 0, 0, 0, 0, 0);   // B
      ex3_stall = 1;
      #1;
      tests_run++;
      if (ex2_stall !== 1'b1) begin tests_failed++; $display("FAIL stall_ex2_first got=%b exp=1", ex2_stall); end
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (ex3_rst_vld !== 1'b1 || ex3_rst !== 64'h3FF0_0000_0000_0001 || ex2_stall !== 1'b1)
            begin tests_failed++; $display("FAIL stall_hold%0d got=%b/%h/%b exp=1/3ff0000000000001/1", i, ex3_rst_vld, ex3_rst, ex2_stall); end
      end
      ex3_stall = 0;
      #1;
      tests_run++;
      if (ex2_stall !== 1'b0) begin tests_failed++; $display("FAIL stall_release got=%b exp=0", ex2_stall); end
      step();
      tests_run++;
      if (ex3_rst_vld !== 1'b1 || ex3_rst !== 64'hC010_0000_0000_0002)
         begin tests_failed++; $display("FAIL stall_capture_b got=%b/%h exp=1/c010000000000002", ex3_rst_vld, ex3_rst); end
      set_idle();
      step();
   endtask

   task automatic test_flush();
      set_op(0, 4'b1000, 0, 11'h400, 52'h5, 0, 0, 0, 0, 0, 0, 1);
      ex3_flush = 1;
      step();
      tests_run++;
      if (ex3_rst_vld !== 1'b0) begin tests_failed++; $display("FAIL flush_capture got=%b exp=0", ex3_rst_vld); end
      // flush beats stall on a valid EX3
      ex3_flush = 0;
      step();
      ex3_stall = 1; ex3_flush = 1;
      step();
      tests_run++;
      if (ex3_rst_vld !== 1'b0) begin tests_failed++; $display("FAIL flush_stall got=%b exp=0", ex3_rst_vld); end
      set_idle();
      step();
   endtask

   task automatic test_reset_mid_stall();
      set_op(0, 4'b1000, 0, 11'h400, 52'h9, 0, 0, 0, 0, 0, 0, 1);
      step();
      ex3_stall = 1;
      step();
      #1;
      cpurst = 1;
      #1;
      tests_run++;
      if (ex3_rst_vld !== 1'b0 || ex3_rst !== 64'h0 || ex3_fflags_nv !== 1'b0)
         begin tests_failed++; $display("FAIL reset_mid_stall got=%b/%h/%b exp=0/0/0", ex3_rst_vld, ex3_rst, ex3_fflags_nv); end
      step();
      cpurst = 0;
      set_idle();
      step();
      tests_run++;
      if (ex3_rst_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_release_idle got=%b exp=0", ex3_rst_vld); end
      set_op(0, 4'b0100, 0, 11'h080, 0, 23'h7, 0, 0, 0, 0, 0, 0);
      step();
      tests_run++;
      if (ex3_rst_vld !== 1'b1 || ex3_rst !== 64'hFFFF_FFFF_4000_0007)
         begin tests_failed++; $display("FAIL reset_first_capture got=%b/%h exp=1/ffffffff40000007", ex3_rst_vld, ex3_rst); end
      set_idle();
      step();
   endtask

   task automatic test_random();
      logic        m_vld;
      logic [63:0] m_rst;
      logic        m_nv;
      logic [3:0]  fmts [4];
      logic        cap;
      fmts[0] = 4'b1000; fmts[1] = 4'b0100; fmts[2] = 4'b0010; fmts[3] = 4'b0001;
      do_reset();
      m_vld = 0; m_rst = 0; m_nv = 0;
      for (int i = 0; i < 300; i++) begin
         set_op($urandom_range(0, 3) == 0, fmts[$urandom_range(0, 3)], 1'($urandom),
                11'($urandom), {20'($urandom), $urandom}, 23'($urandom), 10'($urandom),
                7'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
                {$urandom, $urandom}, 1'($urandom));
         ex2_pipe_vld = $urandom_range(0, 3) != 0;
         ex3_stall    = $urandom_range(0, 2) == 0;
         ex3_flush    = $urandom_range(0, 9) == 0;
         #1;
         tests_run++;
         if (ex2_stall !== (m_vld & ex3_stall))
            begin tests_failed++; $display("FAIL rand_ex2_stall[%0d] got=%b exp=%b", i, ex2_stall, m_vld & ex3_stall); end
         cap = ex2_pipe_vld && !(m_vld && ex3_stall) && !ex3_flush;
         if (cap) begin
            m_rst = ref_pack(ex2_op_cmp, ex2_fmt, ex2_sel_final_sign, ex2_sel_final_e,
                             ex2_double_sel_final_f, ex2_single0_sel_final_f,
                             ex2_half0_sel_final_f, ex2_bhalf0_sel_final_f,
                             double_pipe_ex2_cmp_r, ex2_special_value_vld, ex2_special_rst);
            m_nv = ex2_nv;
         end
         if (ex3_flush) m_vld = 0;
         else if (cap) m_vld = 1;
         else if (!(m_vld && ex3_stall)) m_vld = 0;
         step();
         tests_run++;
         if (ex3_rst_vld !== m_vld || ex3_rst !== m_rst || ex3_fflags_nv !== m_nv)
            begin tests_failed++; $display("FAIL rand_out[%0d] got=%b/%h/%b exp=%b/%h/%b", i, ex3_rst_vld, ex3_rst, ex3_fflags_nv, m_vld, m_rst, m_nv); end
      end
      set_idle();
      step();
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      cpurst = 0;
      set_idle();
      #2;
      test_reset();
      test_formats();
      test_stall();
      test_flush();
      test_reset_mid_stall();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
